// File: rtl/phone_call_gen2_pkg.sv
// phone_call_gen2_pkg: shared states, status strings, printable bounds and hex helper
package phone_call_gen2_pkg;
  typedef enum logic [2:0] {IDLE, RINGING, REJECTED, BUSY, CALL, COST} state_t;
  localparam logic [63:0] STR_IDLE = "IDLE    ";
  localparam logic [63:0] STR_RINGING = "RINGING ";
  localparam logic [63:0] STR_REJECTED = "REJECTED";
  localparam logic [63:0] STR_BUSY = "BUSY    ";
  localparam logic [63:0] STR_CALL = "CALL    ";
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/phone_msg_window.sv
// phone_msg_window: shift window of printable characters, newest in the low byte
module phone_msg_window import phone_call_gen2_pkg::*; #(
  parameter int MSG_CHARS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   load,
  input  logic [7:0]             chr,
  output logic                   accept,
  output logic [8*MSG_CHARS-1:0] window
);
  logic [8*MSG_CHARS-1:0] shifted;
  assign accept = load && chr >= PRINT_LO && chr <= PRINT_HI;
  assign shifted = (window << 8) | (8*MSG_CHARS)'(chr);
  // oldest character falls off the top on each accepted character
  always_ff @(posedge clk or negedge rst)
    if (!rst) window <= '0;
    else window <= clr ? '0 : accept ? shifted : window;
endmodule

// File: rtl/phone_call_gen2.sv
// phone_call_gen2: two-party call sequencer with metered, credit-capped cost
module phone_call_gen2 import phone_call_gen2_pkg::*; #(
  parameter int MSG_CHARS = 8,
  parameter int RING_TIMEOUT = 10,
  parameter int NOTICE_CYCLES = 10,
  parameter int COST_CALLER = 2,
  parameter int COST_CALLEE = 1,
  parameter int COST_PER_CYCLE = 1,
  parameter int COST_W = 32,
  parameter logic [COST_W-1:0] CREDIT_LIMIT = '1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_call,
  input  logic                   answer_call,
  input  logic                   end_call_caller,
  input  logic                   end_call_callee,
  input  logic                   send_char_caller,
  input  logic                   send_char_callee,
  input  logic [7:0]             char_sent,
  output logic [63:0]            status_msg,
  output logic [8*MSG_CHARS-1:0] sent_msg,
  output logic [COST_W-1:0]      cost,
  output logic                   call_active
);
  state_t state, state_n;
  logic [31:0] cnt, cnt_n, cost32;
  logic [COST_W-1:0] cost_n;
  logic [COST_W+1:0] sum;
  logic [63:0] status_n, hex_str;
  logic clr, load, accept;
  assign clr = state == IDLE && start_call;
  assign load = state == CALL && (send_char_caller || send_char_callee);
  phone_msg_window #(.MSG_CHARS(MSG_CHARS)) u_win (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .chr(char_sent),
    .accept(accept), .window(sent_msg)
  );
  // unsaturated next cost; two guard bits keep the sum from wrapping
  always_comb
    sum = {2'b0, cost} + (COST_W+2)'(COST_PER_CYCLE)
        + (accept ? (COST_W+2)'(send_char_caller ? COST_CALLER : COST_CALLEE) : '0);
  // next state, dwell/ring counter and cost
  always_comb begin
    state_n = state;
    cnt_n = cnt + 32'd1;
    cost_n = cost;
    case (state)
      IDLE: begin
        if (start_call) state_n = RINGING;
        if (start_call) cost_n = '0;
      end
      RINGING: state_n = end_call_caller ? IDLE : end_call_callee ? REJECTED :
                         answer_call ? CALL : cnt == 32'(RING_TIMEOUT-1) ? BUSY : RINGING;
      CALL: begin
        cost_n = sum > {2'b0, CREDIT_LIMIT} ? CREDIT_LIMIT : sum[COST_W-1:0];
        if (end_call_caller || end_call_callee || cost == CREDIT_LIMIT) state_n = COST;
      end
      default: if (cnt == 32'(NOTICE_CYCLES-1)) state_n = IDLE;
    endcase
    if (state_n != state || state == IDLE) cnt_n = '0;
  end
  // status text for the state being entered, so the register shows it next cycle
  always_comb begin
    cost32 = 32'(cost_n);
    for (int i = 0; i < 8; i++) hex_str[i*8 +: 8] = hex_ascii(cost32[i*4 +: 4]);
    status_n = state_n == IDLE ? STR_IDLE : state_n == RINGING ? STR_RINGING :
               state_n == REJECTED ? STR_REJECTED : state_n == BUSY ? STR_BUSY :
               state_n == CALL ? STR_CALL : hex_str;
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      cost <= '0;
      status_msg <= STR_IDLE;
      call_active <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cost <= cost_n;
      status_msg <= status_n;
      call_active <= state_n == CALL;
    end
endmodule

// File: tb/tb_phone_call_gen2.sv
// tb_phone_call_gen2: scoreboard bench for default and small-window/low-credit instances
module tb_phone_call_gen2;
  localparam int F_ST = 0, F_MSG = 1, F_COST = 2, F_ACT = 3;
  localparam logic [5:0] ST = 6'b100000, AN = 6'b010000, ER = 6'b001000,
                         EE = 6'b000100, SR = 6'b000010, SE = 6'b000001;
  typedef struct { int cyc; int d; int f; logic [63:0] v; string nm; } exp_t;
  exp_t q[$];
  logic clk = 0, rst0 = 0, rst1 = 0;
  logic [5:0] in0 = 0, in1 = 0;
  logic [7:0] ch0 = 0, ch1 = 0;
  logic [63:0] st0, st1, m0;
  logic [31:0] m1, c0, c1;
  logic a0, a1;
  int cyc = 0, total = 0, pass = 0, k;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  phone_call_gen2 u0 (
    .clk(clk), .rst(rst0), .start_call(in0[5]), .answer_call(in0[4]),
    .end_call_caller(in0[3]), .end_call_callee(in0[2]),
    .send_char_caller(in0[1]), .send_char_callee(in0[0]), .char_sent(ch0),
    .status_msg(st0), .sent_msg(m0), .cost(c0), .call_active(a0)
  );
  phone_call_gen2 #(.MSG_CHARS(4), .CREDIT_LIMIT(32'd20)) u1 (
    .clk(clk), .rst(rst1), .start_call(in1[5]), .answer_call(in1[4]),
    .end_call_caller(in1[3]), .end_call_callee(in1[2]),
    .send_char_caller(in1[1]), .send_char_callee(in1[0]), .char_sent(ch1),
    .status_msg(st1), .sent_msg(m1), .cost(c1), .call_active(a1)
  );

  function automatic logic [63:0] actual(input int d, input int f);
    if (f == F_ST) return d == 0 ? st0 : st1;
    if (f == F_MSG) return d == 0 ? m0 : {32'b0, m1};
    if (f == F_COST) return {32'b0, d == 0 ? c0 : c1};
    return {63'b0, d == 0 ? a0 : a1};
  endfunction

  always @(negedge clk)
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].cyc == cyc) begin
        logic [63:0] a;
        a = actual(q[i].d, q[i].f);
        total++;
        if (a === q[i].v) pass++;
        else $display("FAIL %s dut%0d cyc %0d: got %h want %h", q[i].nm, q[i].d, cyc, a, q[i].v);
        q.delete(i);
      end

  task automatic ex(input int d, input int f, input logic [63:0] v, input string nm, input int c);
    q.push_back('{c, d, f, v, nm});
  endtask

  task automatic drive(input int d, input logic [5:0] v, input logic [7:0] c);
    if (d == 0) begin in0 = v; ch0 = c; end
    else begin in1 = v; ch1 = c; end
    @(negedge clk);
    in0 = 0;
    in1 = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      ex(d, F_ST, "IDLE    ", "rst_status", 1);
      ex(d, F_MSG, 64'h0, "rst_msg", 1);
      ex(d, F_COST, 64'h0, "rst_cost", 1);
      ex(d, F_ACT, 64'h0, "rst_active", 1);
    end
    idle(2);
    rst0 = 1;
    rst1 = 1;
    idle(1);

    k = cyc + 1;
    ex(0, F_ST, "RINGING ", "t1_ring", k);
    ex(0, F_COST, 64'd0, "t1_cost_clr", k);
    ex(0, F_ST, "CALL    ", "t1_call", k + 3);
    ex(0, F_ACT, 64'd1, "t1_active", k + 3);
    ex(0, F_MSG, 64'h48, "t1_msg_H", k + 4);
    ex(0, F_COST, 64'd3, "t1_cost_H", k + 4);
    ex(0, F_MSG, 64'h4869, "t1_msg_Hi", k + 5);
    ex(0, F_MSG, 64'h486921, "t1_msg_Hi!", k + 6);
    ex(0, F_COST, 64'd8, "t1_cost_Hi!", k + 6);
    ex(0, F_ST, 64'h3030303030303039, "t1_cost_disp", k + 7);
    ex(0, F_COST, 64'd9, "t1_cost_final", k + 7);
    ex(0, F_ACT, 64'd0, "t1_inactive", k + 7);
    ex(0, F_ST, 64'h3030303030303039, "t1_cost_disp_last", k + 16);
    ex(0, F_ST, "IDLE    ", "t1_idle", k + 17);
    drive(0, ST, 0);
    idle(2);
    drive(0, AN, 0);
    drive(0, SR, "H");
    drive(0, SR, "i");
    drive(0, SE, "!");
    drive(0, EE, 0);
    idle(12);

    k = cyc + 1;
    ex(0, F_COST, 64'd0, "t2_cost_clr", k);
    ex(0, F_MSG, 64'd0, "t2_msg_clr", k);
    ex(0, F_ST, "RINGING ", "t2_ring_last", k + 9);
    ex(0, F_ST, "BUSY    ", "t2_busy", k + 10);
    ex(0, F_ST, "BUSY    ", "t2_busy_last", k + 19);
    ex(0, F_ST, "IDLE    ", "t2_idle", k + 20);
    drive(0, ST, 0);
    idle(21);

    k = cyc + 1;
    ex(0, F_ST, "REJECTED", "t3_rejected", k + 1);
    ex(0, F_ACT, 64'd0, "t3_inactive", k + 1);
    ex(0, F_ST, "REJECTED", "t3_rej_last", k + 10);
    ex(0, F_ST, "IDLE    ", "t3_idle", k + 11);
    drive(0, ST, 0);
    drive(0, EE | AN, 0);
    drive(0, ST, 0);
    idle(10);

    k = cyc + 1;
    ex(0, F_ACT, 64'd1, "t4_active", k + 1);
    ex(0, F_MSG, 64'd0, "t4_nonprint_msg", k + 3);
    ex(0, F_COST, 64'd2, "t4_nonprint_cost", k + 3);
    ex(0, F_MSG, 64'h41, "t4_both_msg", k + 4);
    ex(0, F_COST, 64'd5, "t4_both_cost", k + 4);
    ex(0, F_ST, 64'h3030303030303042, "t4_hex_B", k + 10);
    ex(0, F_ST, "IDLE    ", "t4_idle", k + 20);
    drive(0, ST, 0);
    drive(0, AN, 0);
    drive(0, SR, 8'h0A);
    drive(0, SR, 8'h7F);
    drive(0, SR | SE, "A");
    idle(5);
    drive(0, ER, 0);
    idle(11);

    k = cyc + 1;
    ex(1, F_MSG, 64'h20, "t5_space", k + 2);
    ex(1, F_MSG, 64'h6263647E, "t5_last4", k + 7);
    ex(1, F_COST, 64'd18, "t5_cost18", k + 7);
    ex(1, F_MSG, 64'h63647E5A, "t5_shift", k + 8);
    ex(1, F_COST, 64'd20, "t5_sat", k + 8);
    ex(1, F_ST, "CALL    ", "t5_still_call", k + 8);
    ex(1, F_ST, 64'h3030303030303134, "t5_forced_cost", k + 9);
    ex(1, F_COST, 64'd20, "t5_sat_hold", k + 9);
    ex(1, F_ACT, 64'd0, "t5_inactive", k + 9);
    ex(1, F_ST, "IDLE    ", "t5_idle", k + 19);
    drive(1, ST, 0);
    drive(1, AN, 0);
    drive(1, SR, 8'h20);
    drive(1, SR, "a");
    drive(1, SR, "b");
    drive(1, SR, "c");
    drive(1, SR, "d");
    drive(1, SR, 8'h7E);
    drive(1, SR, "Z");
    idle(12);

    k = cyc + 1;
    ex(1, F_COST, 64'd3, "t6_pre_cost", k + 2);
    ex(1, F_ACT, 64'd1, "t6_pre_active", k + 2);
    ex(1, F_MSG, 64'h51, "t6_pre_msg", k + 2);
    drive(1, ST, 0);
    drive(1, AN, 0);
    drive(1, SR, "Q");
    @(posedge clk);
    #1 rst1 = 0;
    ex(1, F_ST, "IDLE    ", "t6_async_status", cyc);
    ex(1, F_MSG, 64'd0, "t6_async_msg", cyc);
    ex(1, F_COST, 64'd0, "t6_async_cost", cyc);
    ex(1, F_ACT, 64'd0, "t6_async_active", cyc);
    idle(2);
    rst1 = 1;
    idle(2);

    total++;
    if (st1 === "IDLE    ") pass++;
    else $display("FAIL t6_post_status: got %h", st1);
    total++;
    if (m1 === 32'd0) pass++;
    else $display("FAIL t6_post_msg: got %h", m1);
    total++;
    if (c1 === 32'd0) pass++;
    else $display("FAIL t6_post_cost: got %h", c1);
    total++;
    if (a1 === 1'b0) pass++;
    else $display("FAIL t6_post_active: got %b", a1);
    total++;
    if (st0 === "IDLE    ") pass++;
    else $display("FAIL end_dut0_status: got %h", st0);
    total++;
    if (c0 === 32'd11) pass++;
    else $display("FAIL end_dut0_cost: got %h", c0);
    total++;
    if (m0 === 64'h41) pass++;
    else $display("FAIL end_dut0_msg: got %h", m0);
    total++;
    if (a0 === 1'b0) pass++;
    else $display("FAIL end_dut0_active: got %b", a0);

    while (q.size() > 0) begin
      total++;
      $display("FAIL %s dut%0d: never checked, want %h", q[0].nm, q[0].d, q[0].v);
      q.delete(0);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/phone_call_gen2.md
# phone_call_gen2

Second-generation two-party call controller for the telephone-communication design. It sequences a single call between a caller and a callee (ring, answer, reject, timeout, talk, billing) and accepts printable characters from either party into a parametrised-depth message window. Call cost is metered per character and per connected cycle, and capped by a credit limit that forcibly ends the call. Status is reported as an 8-character ASCII string for the display stage.

## Interface
- MSG_CHARS, 8: depth of the message window in characters (≥1).
- RING_TIMEOUT, 10: cycles in RINGING before BUSY (≥1).
- NOTICE_CYCLES, 10: dwell cycles in REJECTED, BUSY and COST (≥1).
- COST_CALLER, 2: cost units per accepted caller character.
- COST_CALLEE, 1: cost units per accepted callee character.
- COST_PER_CYCLE, 1: cost units per cycle spent in CALL.
- COST_W, 32: cost register width (≤32).
- CREDIT_LIMIT, 2^COST_W−1: cost ceiling.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_call, answer_call, end_call_caller, end_call_callee, send_char_caller, send_char_callee  in  1 each  single-cycle request pulses.
- char_sent  in  8  ASCII character, sampled with send_char_*.
- status_msg  out  64  8 ASCII characters, MSB = leftmost.
- sent_msg  out  8*MSG_CHARS  message window; newest character in the low byte.
- cost  out  COST_W  running/final call cost.
- call_active  out  1  high while in CALL.

## Operation
- States: IDLE, RINGING, REJECTED, BUSY, CALL, COST.
- status_msg per state: "IDLE    ", "RINGING ", "REJECTED", "BUSY    ", "CALL    ". In COST it shows cost as 8 uppercase hex ASCII digits, zero-extended.
- IDLE: start_call → RINGING. Cost and sent_msg clear to 0 on entry to RINGING.
- RINGING, priority high to low:
  - end_call_caller → IDLE.
  - end_call_callee → REJECTED.
  - answer_call → CALL.
  - ring counter expiry → BUSY.
- REJECTED, BUSY, COST: hold exactly NOTICE_CYCLES cycles, then → IDLE. All inputs are ignored.
- CALL:
  - Either end_call_* → COST.
  - Cost reaching CREDIT_LIMIT → COST on the next edge.
  - Characters: send_char_caller has priority if both senders pulse in the same cycle.
  - A character is accepted only if it is printable (0x20–0x7E). Non-printable characters are ignored and cost nothing.
  - On an accepted character, sent_msg shifts left 8 bits and the new character enters the low byte. The oldest character is discarded.
- Cost arithmetic (CALL only): each cycle adds COST_PER_CYCLE plus the accepted-character cost. The sum saturates at CREDIT_LIMIT and never wraps.
- An end request and a character in the same cycle: the character is accepted and charged, then the state moves to COST.
- start_call outside IDLE, and answer_call outside RINGING, are ignored.

## Timing
- All outputs are registered. They reflect the new state in the cycle after the transition edge.
- RINGING entered at edge k with no events → BUSY at edge k+RING_TIMEOUT.
- Dwell states entered at edge k → IDLE at edge k+NOTICE_CYCLES.
- A character sampled at edge k appears in sent_msg and cost after edge k.
- Reset values: state IDLE, status_msg "IDLE    ", sent_msg 0, cost 0, call_active 0, counters 0.
- Reset asserted mid-call aborts immediately; no COST display follows.

## Structure
- Shared package holds:
  - The state enum.
  - The five fixed status strings as 64-bit constants.
  - The printable range bounds.
  - A hex-nibble-to-ASCII function.
- One sub-module is natural: phone_msg_window. It is the parametrised shift buffer with a printable filter, inputs load/char, output window.
- Cost, counters and the FSM stay in the top level.

## Test plan
- start_call, then answer_call 3 cycles later, then caller sends "H","i" and callee sends "!", then end_call_callee. Expect, with defaults:
  - sent_msg low 3 bytes = 0x486921.
  - Cost = 2+2+1 + cycles in CALL.
  - status_msg shows the cost in hex for 10 cycles, then "IDLE    ".
- start_call with no response → "BUSY    " exactly 10 cycles after RINGING entry, then IDLE after 10 more.
- RINGING with end_call_callee and answer_call in the same cycle → REJECTED.
- In CALL, send_char_caller 0x0A and 0x7F → sent_msg unchanged, no character charge. Both senders pulse with 'A' → one 'A' charged at COST_CALLER.
- CREDIT_LIMIT=20, COST_PER_CYCLE=1 → cost saturates at 20 and the call forcibly enters COST with status "00000014".
- MSG_CHARS=4: send 6 characters → only the last 4 are retained. Drive rst low mid-call → all outputs return to reset values asynchronously.
